ddc_agc: RTL

Automatic gain controller for the decimating downconverter's post-CIC left shift (cic_shf, 0..7).
- Sits beside the DDC and watches its quadrature baseband output (valid/i/q) and the 7-bit saturation count (sathld).
- Measures the peak magnitude over fixed blocks of output samples and steps cic_shf up or down by one with hysteresis and a settle delay.
- When AGC is disabled, a manual shift value passes through.

---
 rtl/ddc_agc.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ddc_agc.sv
// Automatic gain control for the DDC post-CIC shift: block peak detection,
// hysteretic one-step shift changes and a settle hold after each change.
module ddc_agc #(
  parameter int osz      = 16,
  parameter int BLK_LOG2 = 10,
  parameter int HI_THR   = 16384,
  parameter int LO_THR   = 4096,
  parameter int SAT_THR  = 1,
  parameter int HOLD_BLK = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic signed [osz-1:0] i_in,
  input  logic signed [osz-1:0] q_in,
  input  logic [6:0]            sathld,
  input  logic                  agc_ena,
  input  logic [2:0]            man_shf,
  output logic [2:0]            cic_shf,
  output logic [osz-1:0]        peak,
  output logic                  step_up,
  output logic                  step_dn,
  output logic [1:0]            state
);

  // Input handshake: valid is a one-cycle strobe with no back-pressure; every
  // cycle with valid=1 carries exactly one new I/Q sample that must be taken.

  typedef enum logic [1:0] {
    S_MANUAL  = 2'd0,
    S_MEASURE = 2'd1,
    S_DECIDE  = 2'd2,
    S_SETTLE  = 2'd3
  } state_t;

  localparam int SW = (HOLD_BLK > 1) ? $clog2(HOLD_BLK) : 1;
  localparam logic [SW-1:0]       SETTLE_LAST = SW'(HOLD_BLK - 1);
  localparam logic [SW-1:0]       SETTLE_ONE  = SW'(1);
  localparam logic [osz-1:0]      MAG_MAX     = {1'b0, {(osz-1){1'b1}}};
  localparam logic [osz-1:0]      MAG_ONE     = osz'(1);
  localparam logic [osz-1:0]      HI_LIM      = osz'(HI_THR);
  localparam logic [osz-1:0]      LO_LIM      = osz'(LO_THR);
  localparam logic [6:0]          SAT_LIM     = 7'(SAT_THR);
  localparam logic [BLK_LOG2-1:0] CNT_ONE     = BLK_LOG2'(1);
  localparam logic [2:0]          SHF_MAX     = 3'd7;

  state_t                st, st_nxt;
  logic [osz-1:0]        acc;
  logic [BLK_LOG2-1:0]   blk_cnt;
  logic [SW-1:0]         settle_cnt;
  logic [6:0]            sat_l;
  logic [osz-1:0]        mag_i, mag_q, smp_mag, acc_max;
  logic                  blk_end;
  logic                  want_dn, want_up;
  logic [2:0]            cic_nxt;
  logic                  up_nxt, dn_nxt;

  // Two's-complement magnitude; the most negative code has no positive
  // counterpart, so it clamps to the largest positive value.
  function automatic logic [osz-1:0] abs_sat(input logic [osz-1:0] x);
    logic [osz-1:0] neg;
    neg = ~x + MAG_ONE;
    if (!x[osz-1])
      abs_sat = x;
    else if (neg[osz-1])
      abs_sat = MAG_MAX;
    else
      abs_sat = neg;
  endfunction

  always_comb begin
    mag_i   = abs_sat(i_in);
    mag_q   = abs_sat(q_in);
    smp_mag = (mag_i > mag_q) ? mag_i : mag_q;
    acc_max = (smp_mag > acc) ? smp_mag : acc;
    blk_end = valid && (st != S_MANUAL) && (&blk_cnt);
  end

  // Decision terms, evaluated against the peak and saturation latched at
  // the previous block end; down wins over up.
  always_comb begin
    want_dn = ((sat_l >= SAT_LIM) || (peak >= HI_LIM)) && (cic_shf != 3'd0);
    want_up = (sat_l == 7'd0) && (peak < LO_LIM) && (cic_shf != SHF_MAX);
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset)
      st <= S_MANUAL;
    else
      st <= st_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    st_nxt = st;
    if (!agc_ena) begin
      st_nxt = S_MANUAL;
    end else begin
      case (st)
        S_MANUAL:  st_nxt = S_MEASURE;
        S_MEASURE: if (blk_end) st_nxt = S_DECIDE;
        S_DECIDE:  st_nxt = (want_dn || want_up) ? S_SETTLE : S_MEASURE;
        S_SETTLE:  if (blk_end && (settle_cnt == SETTLE_LAST)) st_nxt = S_MEASURE;
        default:   st_nxt = S_MANUAL;
      endcase
    end
  end

  // FSM: output logic (next values for the registered shift and pulses)
  always_comb begin
    cic_nxt = cic_shf;
    up_nxt  = 1'b0;
    dn_nxt  = 1'b0;
    if (!agc_ena) begin
      cic_nxt = man_shf;
    end else if (st == S_DECIDE) begin
      if (want_dn) begin
        cic_nxt = cic_shf - 3'd1;
        dn_nxt  = 1'b1;
      end else if (want_up) begin
        cic_nxt = cic_shf + 3'd1;
        up_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cic_shf <= 3'd0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      cic_shf <= cic_nxt;
      step_up <= up_nxt;
      step_dn <= dn_nxt;
    end
  end

  // Block measurement; counting carries on through DECIDE and SETTLE so the
  // block boundaries stay on a fixed grid while AGC is enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      blk_cnt    <= '0;
      settle_cnt <= '0;
      sat_l      <= 7'd0;
      peak       <= '0;
    end else if (st == S_MANUAL) begin
      acc        <= '0;
      blk_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      if (valid) begin
        blk_cnt <= blk_cnt + CNT_ONE;
        acc     <= blk_end ? '0 : acc_max;
      end
      if (blk_end) begin
        peak  <= acc_max;
        sat_l <= sathld;
      end
      if (st == S_DECIDE)
        settle_cnt <= '0;
      else if ((st == S_SETTLE) && blk_end)
        settle_cnt <= settle_cnt + SETTLE_ONE;
    end
  end

  assign state = st;

endmodule
